// File: rtl/lmem_access_arbiter.sv
// Local-memory access arbiter: round-robin shares the mcu between the host
// byte port (line load/unload) and the compute engine (chunk write/read),
// sequences the mcu enables and cross-checks the mcu done_flag.
module lmem_access_arbiter #(
  parameter int NUM_BITS = 512,
  parameter int RD_LAT   = 1,
  localparam int BYTES   = NUM_BITS / 8,
  localparam int IDX_W   = (BYTES > 1) ? $clog2(BYTES) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             host_req,
  input  logic             host_dir,
  input  logic             host_beat,
  output logic             host_grant,
  output logic [IDX_W-1:0] host_byte_idx,
  output logic             host_done,
  input  logic             cmp_req,
  input  logic             cmp_dir,
  output logic             cmp_grant,
  output logic             cmp_done,
  output logic             mcu_line_rd_host_en,
  output logic             mcu_line_wr_host_en,
  output logic             mcu_chunk_load_en,
  input  logic             mcu_done_flag,
  output logic             busy,
  output logic             proto_err
);

  localparam int RD_W = (RD_LAT > 1) ? $clog2(RD_LAT + 1) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTES - 1);
  localparam logic [RD_W-1:0]  LAST_RD  = RD_W'(RD_LAT - 1);

  typedef enum logic [2:0] {
    IDLE, HOST_XFER, HOST_CHK, CMP_WR, CMP_RD, DONE
  } state_t;

  state_t           state, nxt;
  logic             owner_host;   // 1: host owns the current transaction
  logic             dir_q;        // direction latched at grant
  logic             rr_host;      // tie winner for the next simultaneous request
  logic [RD_W-1:0]  rd_cnt;
  logic             grant_host, grant_cmp, last_beat;

  // Arbitration decision; only taken in IDLE so DONE never issues a grant
  always_comb begin
    grant_host = (state == IDLE) && host_req && (!cmp_req || rr_host);
    grant_cmp  = (state == IDLE) && cmp_req && !grant_host;
    last_beat  = (state == HOST_XFER) && host_beat && (host_byte_idx == LAST_IDX);
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= nxt;
  end

  // Next-state logic
  always_comb begin
    nxt = state;
    unique case (state)
      IDLE: begin
        if (grant_host)     nxt = HOST_XFER;
        else if (grant_cmp) nxt = cmp_dir ? CMP_RD : CMP_WR;
      end
      HOST_XFER: if (last_beat) nxt = HOST_CHK;
      HOST_CHK:  nxt = DONE;
      CMP_WR:    nxt = DONE;
      CMP_RD:    if (rd_cnt == LAST_RD) nxt = DONE;
      DONE:      nxt = IDLE;
      default:   nxt = IDLE;
    endcase
  end

  // Grant bookkeeping, byte index, read-latency counter and sticky error
  always_ff @(posedge clk) begin
    if (rst) begin
      owner_host    <= 1'b0;
      dir_q         <= 1'b0;
      rr_host       <= 1'b1;
      host_byte_idx <= '0;
      rd_cnt        <= '0;
      proto_err     <= 1'b0;
    end else begin
      if (grant_host) begin
        owner_host <= 1'b1;
        dir_q      <= host_dir;
        rr_host    <= 1'b0;
      end else if (grant_cmp) begin
        owner_host <= 1'b0;
        dir_q      <= cmp_dir;
        rr_host    <= 1'b1;
      end
      if (state == HOST_XFER && host_beat)
        host_byte_idx <= (host_byte_idx == LAST_IDX) ? '0 : host_byte_idx + IDX_W'(1);
      rd_cnt <= (state == CMP_RD) ? rd_cnt + RD_W'(1) : '0;
      // done_flag must arrive exactly in the check cycle; coinciding with the
      // last beat is tolerated, anything earlier is a protocol error
      if ((state == HOST_CHK && !mcu_done_flag) ||
          (state == HOST_XFER && mcu_done_flag && !last_beat))
        proto_err <= 1'b1;
    end
  end

  // Outputs decoded from state; host line enables follow host_beat directly
  always_comb begin
    host_grant          = (state != IDLE) && owner_host;
    cmp_grant           = (state != IDLE) && !owner_host;
    host_done           = (state == DONE) && owner_host;
    cmp_done            = (state == DONE) && !owner_host;
    mcu_line_rd_host_en = (state == HOST_XFER) && host_beat && !dir_q;
    mcu_line_wr_host_en = (state == HOST_XFER) && host_beat && dir_q;
    mcu_chunk_load_en   = (state == CMP_WR);
    busy                = (state != IDLE);
  end

endmodule

// File: tb/tb_lmem_access_arbiter.sv
// Bench for lmem_access_arbiter: table of single transactions plus
// hand-written tie-break and mid-transaction reset sequences; a scoreboard
// checks owner, enable count and proto_err at every done pulse.
module tb_lmem_access_arbiter;

  localparam int BYTES  = 64;
  localparam int RD_LAT = 1;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       host_req = 1'b0, host_dir = 1'b0, host_beat = 1'b0;
  logic       cmp_req = 1'b0, cmp_dir = 1'b0;
  logic       mcu_done_flag = 1'b0;
  logic       host_grant, host_done, cmp_grant, cmp_done;
  logic       mcu_line_rd_host_en, mcu_line_wr_host_en, mcu_chunk_load_en;
  logic       busy, proto_err;
  logic [5:0] host_byte_idx;

  lmem_access_arbiter #(.NUM_BITS(512), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .rst(rst),
    .host_req(host_req), .host_dir(host_dir), .host_beat(host_beat),
    .host_grant(host_grant), .host_byte_idx(host_byte_idx), .host_done(host_done),
    .cmp_req(cmp_req), .cmp_dir(cmp_dir), .cmp_grant(cmp_grant), .cmp_done(cmp_done),
    .mcu_line_rd_host_en(mcu_line_rd_host_en), .mcu_line_wr_host_en(mcu_line_wr_host_en),
    .mcu_chunk_load_en(mcu_chunk_load_en), .mcu_done_flag(mcu_done_flag),
    .busy(busy), .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit    is_host;
    bit    dir;
    int    stall_n;   // beat dropped every stall_n-th cycle, 0 = never
    bit    bad_flag;  // mcu withholds done_flag
    bit    exp_perr;
    string name;
  } vec_t;

  typedef struct {
    bit is_host;
    int en;
    bit perr;
  } sb_t;

  int   checks = 0;
  int   errors = 0;
  int   done_seen = 0;
  int   en_cnt = 0;
  sb_t  sb_q[$];
  sb_t  sb_e;
  vec_t vecs[6];
  bit   bad_flag = 1'b0;
  bit   pend = 1'b0;
  int   mcu_beats = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0d want=%0d", nm, act, exp);
    end
  endtask

  // Minimal mcu: counts line enables and raises done_flag the cycle after the last byte
  always @(negedge clk) begin
    pend = 1'b0;
    if (rst) mcu_beats = 0;
    else if (mcu_line_rd_host_en || mcu_line_wr_host_en) begin
      mcu_beats++;
      if (mcu_beats == BYTES) begin
        mcu_beats = 0;
        pend = 1'b1;
      end
    end
  end

  always @(posedge clk) begin
    #1;
    mcu_done_flag = pend && !bad_flag;
  end

  // Scoreboard and invariant monitor
  always @(negedge clk) begin
    if (rst) begin
      sb_q.delete();
      en_cnt = 0;
    end else begin
      en_cnt += int'(mcu_line_rd_host_en) + int'(mcu_line_wr_host_en) + int'(mcu_chunk_load_en);
      chk("one_grant", 32'(host_grant && cmp_grant), 0);
      chk("one_en", 32'((int'(mcu_line_rd_host_en) + int'(mcu_line_wr_host_en)
                         + int'(mcu_chunk_load_en)) > 1), 0);
      chk("idle_en", 32'(!busy && (mcu_line_rd_host_en || mcu_line_wr_host_en
                                   || mcu_chunk_load_en)), 0);
      if (host_done || cmp_done) begin
        done_seen++;
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_unexpected_done host_done=%0d cmp_done=%0d", host_done, cmp_done);
        end else begin
          sb_e = sb_q.pop_front();
          chk("sb_owner", 32'(host_done), 32'(sb_e.is_host));
          chk("sb_en_cycles", en_cnt, sb_e.en);
          chk("sb_proto_err", 32'(proto_err), 32'(sb_e.perr));
        end
        en_cnt = 0;
      end
    end
  end

  task automatic run_txn(input vec_t v);
    int   k, nb, xfer_n, done_c, exp_idx, exp_lat;
    logic b, in_x;
    k = 0; nb = 0; xfer_n = 0; done_c = -1; exp_idx = 0;
    @(posedge clk); #1;
    bad_flag = v.bad_flag;
    if (v.is_host) begin host_req = 1'b1; host_dir = v.dir; end
    else begin cmp_req = 1'b1; cmp_dir = v.dir; end
    sb_q.push_back('{v.is_host, (v.is_host ? BYTES : (v.dir ? 0 : 1)), v.exp_perr});
    @(negedge clk);
    chk({v.name, "_idle_busy"}, 32'(busy), 0);
    for (int c = 1; c <= 400 && done_c < 0; c++) begin
      @(posedge clk); #1;
      host_req = 1'b0;
      cmp_req  = 1'b0;
      in_x = v.is_host && (nb < BYTES);
      if (in_x) begin
        k++;
        b = (v.stall_n == 0) || (k % v.stall_n != 0);
      end else b = 1'b0;
      host_beat = b;
      @(negedge clk);
      if (c == 1) chk({v.name, "_grant"}, 32'(v.is_host ? host_grant : cmp_grant), 1);
      if (in_x) begin
        chk({v.name, "_idx"}, 32'(host_byte_idx), exp_idx);
        chk({v.name, "_rd_en"}, 32'(mcu_line_rd_host_en), 32'(b && !v.dir));
        chk({v.name, "_wr_en"}, 32'(mcu_line_wr_host_en), 32'(b && v.dir));
        if (b) begin
          exp_idx = (exp_idx + 1) % BYTES;
          nb++;
          if (nb == BYTES) xfer_n = k;
        end
      end
      if (v.is_host ? host_done : cmp_done) done_c = c;
    end
    exp_lat = v.is_host ? xfer_n + 2 : (v.dir ? RD_LAT + 1 : 2);
    chk({v.name, "_done_latency"}, done_c, exp_lat);
    @(posedge clk); #1;
    host_beat = 1'b0;
    @(negedge clk);
    chk({v.name, "_grants_off"}, 32'({host_grant, cmp_grant, busy}), 0);
    chk({v.name, "_idx_end"}, 32'(host_byte_idx), 0);
    chk({v.name, "_proto_err"}, 32'(proto_err), 32'(v.exp_perr));
    bad_flag = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0] = '{1'b0, 1'b0, 0, 1'b0, 1'b0, "cmp_wr"};
    vecs[1] = '{1'b0, 1'b1, 0, 1'b0, 1'b0, "cmp_rd"};
    vecs[2] = '{1'b1, 1'b0, 0, 1'b0, 1'b0, "host_load"};
    vecs[3] = '{1'b1, 1'b1, 3, 1'b0, 1'b0, "host_unload_stall"};
    vecs[4] = '{1'b1, 1'b0, 0, 1'b1, 1'b1, "host_bad_flag"};
    vecs[5] = '{1'b0, 1'b0, 0, 1'b0, 1'b1, "cmp_wr_sticky"};

    // reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs", 32'({host_grant, host_byte_idx, host_done, cmp_grant, cmp_done,
                              mcu_line_rd_host_en, mcu_line_wr_host_en, mcu_chunk_load_en,
                              busy, proto_err}), 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // simultaneous requests held: host first, then alternating
    host_req = 1'b1; host_dir = 1'b0; cmp_req = 1'b1; cmp_dir = 1'b0; host_beat = 1'b1;
    sb_q.push_back('{1'b1, BYTES, 1'b0});
    sb_q.push_back('{1'b0, 1, 1'b0});
    sb_q.push_back('{1'b1, BYTES, 1'b0});
    sb_q.push_back('{1'b0, 1, 1'b0});
    done_seen = 0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("tie_first_host", 32'({host_grant, cmp_grant}), 32'b10);
    for (int c = 0; c < 600; c++) begin
      @(posedge clk); #1;
      if (done_seen >= 4) break;
    end
    host_req = 1'b0; cmp_req = 1'b0; host_beat = 1'b0;
    chk("tie_done_count", done_seen, 4);
    chk("tie_sb_drained", sb_q.size(), 0);
    @(negedge clk);
    chk("tie_idle_after", 32'({busy, host_grant, cmp_grant}), 0);

    // single-transaction table
    for (int i = 0; i < 6; i++) run_txn(vecs[i]);

    // reset during beat 20 of a host load
    @(posedge clk); #1;
    host_req = 1'b1; host_dir = 1'b0;
    sb_q.push_back('{1'b1, BYTES, 1'b0});
    for (int c = 1; c <= 21; c++) begin
      @(posedge clk); #1;
      host_req = 1'b0;
      host_beat = 1'b1;
      if (c == 21) rst = 1'b1;
      @(negedge clk);
      if (c == 21) begin
        chk("rst_mid_idx", 32'(host_byte_idx), 20);
        chk("rst_mid_en", 32'(mcu_line_rd_host_en), 1);
      end
    end
    @(posedge clk); #1;
    rst = 1'b0; host_beat = 1'b0;
    @(negedge clk);
    chk("rst_abort_outputs", 32'({host_grant, host_byte_idx, host_done, cmp_grant, cmp_done,
                                  mcu_line_rd_host_en, mcu_line_wr_host_en, mcu_chunk_load_en,
                                  busy, proto_err}), 0);
    run_txn('{1'b0, 1'b0, 0, 1'b0, 1'b0, "post_rst_cmp_wr"});
    run_txn('{1'b1, 1'b0, 0, 1'b0, 1'b0, "post_rst_host_load"});

    chk("sb_leftover", sb_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
